// File: rtl/qword_bus_controller_pkg.sv
// Shared widths and state encoding for the qword bus controller.
package qword_bus_controller_pkg;

    localparam int BUS_DATA_WIDTH_SHIFT = 4;
    localparam int BUS_DATA_WIDTH       = 128;
    localparam int MEM_WORD_SHIFT       = 2;
    localparam int MEM_DATA_WIDTH       = 32;
    localparam int BEATS_PER_QWORD      = 4;
    localparam int BEAT_WIDTH           = $clog2(BEATS_PER_QWORD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/qword_bus_controller_increment.sv
// Plain binary increment with carry-out; the carry doubles as a wrap flag.
module qword_bus_controller_increment #(
    parameter int DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  carry_o
);

    // carry_o is set when data_i is all ones (the increment wraps to zero)
    assign {carry_o, data_o} = {1'b0, data_i} + {{DATA_WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/qword_bus_controller.sv
// Serializes one 128-bit cache transfer into four 32-bit word accesses.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a cache request; accepts it the cycle seen
// ST_XFER    | issuing word beat 0..3, advancing on mem_ready_i
// ST_ACK     | one-cycle completion pulse to the cache
// ST_RELEASE | waiting for the cache to drop bus_valid_i
module qword_bus_controller
    import qword_bus_controller_pkg::*;
#(
    parameter int BUS_ADDRESS_WIDTH = 20
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] bus_addr_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     bus_data_i,
    input  logic                                          bus_we_i,
    input  logic                                          bus_valid_i,
    output logic                                          bus_valid_o,
    output logic [BUS_DATA_WIDTH-1:0]                     bus_data_o,
    output logic                                          mem_req_o,
    output logic [BUS_ADDRESS_WIDTH-MEM_WORD_SHIFT-1:0]   mem_addr_o,
    output logic                                          mem_we_o,
    output logic [MEM_DATA_WIDTH-1:0]                     mem_data_o,
    input  logic                                          mem_ready_i,
    input  logic [MEM_DATA_WIDTH-1:0]                     mem_data_i
);

    localparam int QADDR_WIDTH = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;

    state_t                  state_q, state_d;
    logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
    logic [QADDR_WIDTH-1:0]  qaddr_q, qaddr_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [BUS_DATA_WIDTH-1:0] stage_q, stage_d;
    logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BEAT_WIDTH-1:0]   beat_inc;
    logic                    beat_last;

    qword_bus_controller_increment #(
        .DATA_WIDTH (BEAT_WIDTH)
    ) u_beat_inc (
        .data_i  (beat_q),
        .data_o  (beat_inc),
        .carry_o (beat_last)
    );

    // Next-state logic; request fields are latched only on acceptance so later bus changes are ignored
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        qaddr_d = qaddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        stage_d = stage_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_valid_i) begin
                    qaddr_d = bus_addr_i;
                    wdata_d = bus_data_i;
                    we_d    = bus_we_i;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem_ready_i) begin
                    if (!we_q) begin
                        stage_d[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_data_i;
                    end
                    beat_d = beat_inc;
                    if (beat_last) begin
                        state_d = ST_ACK;
                        // publish the whole qword at once so the cache never sees partial data
                        if (!we_q) begin
                            rdata_d = stage_d;
                        end
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            qaddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            stage_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            qaddr_q <= qaddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            stage_q <= stage_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded from registered state only; no input reaches an output combinationally
    always_comb begin
        mem_req_o   = (state_q == ST_XFER);
        mem_we_o    = (state_q == ST_XFER) && we_q;
        mem_addr_o  = {qaddr_q, beat_q};
        mem_data_o  = wdata_q[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        bus_valid_o = (state_q == ST_ACK);
        bus_data_o  = rdata_q;
    end

endmodule

// File: tb/tb_qword_bus_controller.sv
// Directed plus randomized bench for qword_bus_controller with a word-array memory model.
module tb_qword_bus_controller;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [15:0]   bus_addr_i;
    logic [127:0]  bus_data_i;
    logic          bus_we_i;
    logic          bus_valid_i;
    logic          bus_valid_o;
    logic [127:0]  bus_data_o;
    logic          mem_req_o;
    logic [17:0]   mem_addr_o;
    logic          mem_we_o;
    logic [31:0]   mem_data_o;
    logic          mem_ready_i;
    logic [31:0]   mem_data_i;

    logic [31:0]   mem [0:(1<<18)-1];
    logic [127:0]  last_read;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cycle_cnt = 0;
    int            ack_cycle = 0;

    qword_bus_controller #(.BUS_ADDRESS_WIDTH(20)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_addr_i  (bus_addr_i),
        .bus_data_i  (bus_data_i),
        .bus_we_i    (bus_we_i),
        .bus_valid_i (bus_valid_i),
        .bus_valid_o (bus_valid_o),
        .bus_data_o  (bus_data_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_data_o  (mem_data_o),
        .mem_ready_i (mem_ready_i),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cycle_cnt++;
    endtask

    function automatic logic [17:0] waddr(input logic [15:0] a, input int k);
        logic [1:0] b;
        b = k[1:0];
        return {a, b};
    endfunction

    // Cycle T is the current cycle: the request is presented now and accepted at the next edge.
    task automatic do_xfer(input logic [15:0] a, input logic we, input logic [127:0] d,
                           input int stall_beat, input int stall_n, input int abort_beat);
        int k;
        int cyc;
        int left;
        bit done;
        logic [127:0] exp_rd;
        bus_valid_i = 1'b1;
        bus_addr_i  = a;
        bus_we_i    = we;
        bus_data_i  = d;
        mem_ready_i = 1'($urandom_range(1));
        mem_data_i  = $urandom;
        for (int i = 0; i < 4; i++) exp_rd[32*i +: 32] = mem[waddr(a, i)];
        k = 0; cyc = 0; left = stall_n; done = 1'b0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            if (cyc == 1) begin
                bus_addr_i = 16'($urandom);
                bus_we_i   = 1'($urandom_range(1));
                bus_data_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if (k < 4) begin
                chk("mem_req", 128'(mem_req_o), 128'(1));
                chk("mem_addr", 128'(mem_addr_o), 128'(waddr(a, k)));
                chk("mem_we", 128'(mem_we_o), 128'(we));
                if (we) chk("mem_data", 128'(mem_data_o), 128'(d[32*k +: 32]));
                chk("no_early_ack", 128'(bus_valid_o), 128'(0));
                chk("bus_data_held", bus_data_o, last_read);
                if (k == abort_beat) begin
                    rst_i = 1'b1;
                    bus_valid_i = 1'b0;
                    step();
                    rst_i = 1'b0;
                    chk("abort_req", 128'(mem_req_o), 128'(0));
                    chk("abort_ack", 128'(bus_valid_o), 128'(0));
                    chk("abort_addr", 128'(mem_addr_o), 128'(0));
                    chk("abort_wdata", 128'(mem_data_o), 128'(0));
                    last_read = '0;
                    chk("abort_bus_data", bus_data_o, last_read);
                    for (int i = 0; i < 6; i++) begin
                        mem_ready_i = 1'($urandom_range(1));
                        step();
                        chk("abort_no_ack", 128'(bus_valid_o), 128'(0));
                        chk("abort_no_req", 128'(mem_req_o), 128'(0));
                    end
                    return;
                end
                if (k == stall_beat && left > 0) begin
                    mem_ready_i = 1'b0;
                    mem_data_i  = $urandom;
                    left--;
                end else begin
                    mem_ready_i = 1'b1;
                    if (we) mem[mem_addr_o] = mem_data_o;
                    else    mem_data_i = mem[mem_addr_o];
                    k++;
                end
            end else begin
                chk("ack", 128'(bus_valid_o), 128'(1));
                chk("ack_req_low", 128'(mem_req_o), 128'(0));
                chk("ack_latency", 128'(cyc), 128'(5 + stall_n));
                if (!we) last_read = exp_rd;
                chk("ack_bus_data", bus_data_o, last_read);
                ack_cycle   = cycle_cnt;
                mem_ready_i = 1'($urandom_range(1));
                mem_data_i  = $urandom;
                done = 1'b1;
            end
        end
        if (!done) chk("xfer_timeout", 128'(0), 128'(1));
        if (done && we) begin
            for (int i = 0; i < 4; i++)
                chk("mem_contents", 128'(mem[waddr(a, i)]), 128'(d[32*i +: 32]));
        end
    endtask

    // Cache-style release: valid falls the cycle after ack, DUT idles the cycle after that.
    task automatic drop_valid();
        step();
        bus_valid_i = 1'b0;
        chk("release_no_ack", 128'(bus_valid_o), 128'(0));
        chk("release_no_req", 128'(mem_req_o), 128'(0));
        step();
        chk("idle_bus_data", bus_data_o, last_read);
    endtask

    initial begin
        int ack_a;
        logic [15:0]  ra;
        logic [127:0] rd;
        logic         rwe;
        rst_i = 1'b1;
        bus_valid_i = 1'b0;
        bus_addr_i = '0;
        bus_data_i = '0;
        bus_we_i = 1'b0;
        mem_ready_i = 1'b1;
        mem_data_i = '0;
        last_read = '0;
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_valid", 128'(bus_valid_o), 128'(0));
        chk("rst_req", 128'(mem_req_o), 128'(0));
        chk("rst_we", 128'(mem_we_o), 128'(0));
        chk("rst_addr", 128'(mem_addr_o), 128'(0));
        chk("rst_wdata", 128'(mem_data_o), 128'(0));
        chk("rst_bus_data", bus_data_o, 128'(0));
        step();

        // directed write, then read with 0x11..0x44
        do_xfer(16'h0123, 1'b1, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, -1, 0, -1);
        chk("wr_first_word_addr", 128'(waddr(16'h0123, 0)), 128'(18'h048C));
        drop_valid();
        mem[18'h40] = 32'h11; mem[18'h41] = 32'h22; mem[18'h42] = 32'h33; mem[18'h43] = 32'h44;
        do_xfer(16'h0010, 1'b0, '0, -1, 0, -1);
        chk("rd_exact", bus_data_o, 128'h00000044_00000033_00000022_00000011);
        drop_valid();

        // stalled read: 3 not-ready cycles on beat 1, ack at T+8
        mem[18'h1000] = 32'hCAFE0000; mem[18'h1001] = 32'hCAFE0001;
        mem[18'h1002] = 32'hCAFE0002; mem[18'h1003] = 32'hCAFE0003;
        do_xfer(16'h0400, 1'b0, '0, 1, 3, -1);
        // held valid for 5 cycles after ack: nothing new may start
        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_no_req", 128'(mem_req_o), 128'(0));
            chk("held_no_ack", 128'(bus_valid_o), 128'(0));
        end
        bus_valid_i = 1'b0;
        step();
        chk("held_bus_data", bus_data_o, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

        // back-to-back write then read, acks 7 cycles apart
        do_xfer(16'hBEEF, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0, -1);
        ack_a = ack_cycle;
        drop_valid();
        do_xfer(16'hBEEF, 1'b0, '0, -1, 0, -1);
        chk("b2b_ack_gap", 128'(ack_cycle - ack_a), 128'(7));
        drop_valid();

        // reset during beat 2 of a write, then a fresh read
        do_xfer(16'h0777, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 2);
        for (int i = 0; i < 4; i++) mem[waddr(16'h0999, i)] = $urandom;
        do_xfer(16'h0999, 1'b0, '0, -1, 0, -1);
        drop_valid();

        // randomized transfers
        for (int n = 0; n < 16; n++) begin
            ra  = 16'($urandom);
            rwe = 1'($urandom_range(1));
            rd  = {$urandom, $urandom, $urandom, $urandom};
            if (!rwe) for (int i = 0; i < 4; i++) mem[waddr(ra, i)] = $urandom;
            do_xfer(ra, rwe, rd, int'($urandom_range(3)), int'($urandom_range(3)), -1);
            drop_valid();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
